// File: rtl/mayo_shake_pkg.sv
// Shared types and constants for the MAYO SHAKE AXI4-Lite controller.
// Register map, CTRL/STATUS bit positions, response codes and the FSM state type.
package mayo_shake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABSORB  = 2'd1,
    ST_SQUEEZE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIN    = 4'h8;
  localparam logic [3:0] ADDR_DOUT   = 4'hC;

  // Word indices (byte offset >> 2) used by the decoders.
  localparam logic [1:0] REG_CTRL   = ADDR_CTRL[3:2];
  localparam logic [1:0] REG_STATUS = ADDR_STATUS[3:2];
  localparam logic [1:0] REG_DIN    = ADDR_DIN[3:2];
  localparam logic [1:0] REG_DOUT   = ADDR_DOUT[3:2];

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_MODE      = 1;
  localparam int unsigned CTRL_LAST      = 2;
  localparam int unsigned CTRL_SQLEN_LSB = 16;
  localparam int unsigned CTRL_SQLEN_MSB = 23;

  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_DIN_FULL   = 1;
  localparam int unsigned STAT_DOUT_VALID = 2;
  localparam int unsigned STAT_DONE       = 3;
  localparam int unsigned STAT_STATE_LSB  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [8:0] sq_target(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/mayo_axil_regif.sv
// AXI4-Lite slave handshake and response logic for the 4-word SHAKE register map.
// Exposes single-cycle write/read strobes; the parent supplies read data and error flags.
module mayo_axil_regif
  import mayo_shake_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            din_full,
  output logic                            wr_en,
  output logic [1:0]                      wr_word,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                            wr_err,
  output logic                            rd_en,
  output logic [1:0]                      rd_word,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
  input  logic                            rd_err
);

  logic aw_arm;
  logic ar_arm;
  logic unused_ok;

  assign wr_word = S_AXI_AWADDR[3:2];
  assign wr_data = S_AXI_WDATA;
  assign rd_word = S_AXI_ARADDR[3:2];
  assign unused_ok = &{1'b0, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready is a registered one-cycle pulse; a DIN write is held off while the holding buffer is occupied.
  assign aw_arm = !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID
                  && !(wr_word == REG_DIN && din_full);
  assign ar_arm = !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
  assign wr_en  = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en  = S_AXI_ARREADY && S_AXI_ARVALID;
  assign S_AXI_WREADY = S_AXI_AWREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_AWREADY <= aw_arm;
      S_AXI_ARREADY <= ar_arm;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mayo_shake_ctrl.sv
// SHAKE128/256 run controller behind an AXI4-Lite register map.
// Sequences absorb/squeeze of an external SHAKE core through 1-entry DIN/DOUT buffers.
module mayo_shake_ctrl
  import mayo_shake_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic                            core_mode,
  output logic [31:0]                     core_din,
  output logic                            core_din_last,
  output logic                            core_din_valid,
  input  logic                            core_din_ready,
  input  logic [31:0]                     core_dout,
  input  logic                            core_dout_valid,
  output logic                            core_dout_ready
);

  state_t      state, state_n;
  logic        wr_en, rd_en, wr_err, rd_err;
  logic [1:0]  wr_word, rd_word;
  logic [31:0] wr_data, rd_data;
  logic        ctrl_mode, ctrl_last;
  logic [7:0]  ctrl_sqlen, run_len;
  logic        din_full, dout_full, done;
  logic [31:0] dout_buf;
  logic [8:0]  sq_cnt;
  logic        start_req, din_wr_ok, din_xfer, dout_cap, dout_rd, sq_last, done_set, done_w1c;

  mayo_axil_regif #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
  ) u_regif (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .din_full      (din_full),
    .wr_en         (wr_en),
    .wr_word       (wr_word),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .rd_en         (rd_en),
    .rd_word       (rd_word),
    .rd_data       (rd_data),
    .rd_err        (rd_err)
  );

  assign core_din_valid  = din_full;
  assign core_dout_ready = (state == ST_SQUEEZE && !dout_full) || state == ST_FLUSH;

  assign start_req = wr_en && wr_word == REG_CTRL && wr_data[CTRL_START];
  assign din_wr_ok = wr_en && wr_word == REG_DIN && state == ST_ABSORB;
  assign wr_err    = wr_word == REG_DIN && state != ST_ABSORB;
  assign din_xfer  = din_full && core_din_ready;
  assign dout_cap  = core_dout_valid && core_dout_ready && state == ST_SQUEEZE;
  assign dout_rd   = rd_en && rd_word == REG_DOUT && dout_full;
  assign sq_last   = dout_rd && state == ST_SQUEEZE && (sq_cnt + 9'd1 == sq_target(run_len));
  assign done_set  = sq_last && !start_req;
  assign done_w1c  = wr_en && wr_word == REG_STATUS && wr_data[STAT_DONE];

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (start_req) state_n = ST_ABSORB;
      ST_ABSORB:  if (start_req) state_n = ST_FLUSH;
                  else if (din_xfer && core_din_last) state_n = ST_SQUEEZE;
      ST_SQUEEZE: if (start_req) state_n = ST_FLUSH;
                  else if (sq_last) state_n = ST_IDLE;
      ST_FLUSH:   state_n = start_req ? ST_FLUSH : ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (rd_word)
      REG_CTRL:   rd_data = {8'h00, ctrl_sqlen, 13'h0000, ctrl_last, ctrl_mode, 1'b0};
      REG_STATUS: rd_data = {26'h0, state, done, dout_full, din_full, state != ST_IDLE};
      REG_DIN:    rd_data = core_din;
      REG_DOUT: begin
        rd_data = dout_full ? dout_buf : '0;
        rd_err  = !dout_full;
      end
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      core_start    <= 1'b0;
      core_mode     <= 1'b0;
      run_len       <= '0;
      ctrl_mode     <= 1'b0;
      ctrl_last     <= 1'b0;
      ctrl_sqlen    <= '0;
      core_din      <= '0;
      core_din_last <= 1'b0;
      din_full      <= 1'b0;
      dout_buf      <= '0;
      dout_full     <= 1'b0;
      sq_cnt        <= '0;
      done          <= 1'b0;
    end else begin
      state      <= state_n;
      core_start <= start_req && state == ST_IDLE;
      if (start_req && state == ST_IDLE) begin
        core_mode <= wr_data[CTRL_MODE];
        run_len   <= wr_data[CTRL_SQLEN_MSB:CTRL_SQLEN_LSB];
        sq_cnt    <= '0;
      end else if (dout_rd && sq_cnt != '1) begin
        sq_cnt <= sq_cnt + 9'd1;
      end
      if (wr_en && wr_word == REG_CTRL) begin
        ctrl_mode  <= wr_data[CTRL_MODE];
        ctrl_last  <= wr_data[CTRL_LAST];
        ctrl_sqlen <= wr_data[CTRL_SQLEN_MSB:CTRL_SQLEN_LSB];
      end
      if (din_wr_ok) begin
        core_din      <= wr_data;
        core_din_last <= ctrl_last;
        din_full      <= 1'b1;
        ctrl_last     <= 1'b0;
      end else if (din_xfer) begin
        din_full <= 1'b0;
      end
      if (dout_cap) begin
        dout_buf  <= core_dout;
        dout_full <= 1'b1;
      end else if (dout_rd) begin
        dout_full <= 1'b0;
      end
      // A flush abandons both buffers; it overrides any capture or write above.
      if (state_n == ST_FLUSH) begin
        din_full  <= 1'b0;
        dout_full <= 1'b0;
      end
      if (done_set) done <= 1'b1;
      else if (done_w1c || state == ST_FLUSH) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mayo_shake_ctrl.sv
// Directed scoreboard bench for mayo_shake_ctrl: expected B/R responses are queued
// by the stimulus and popped by an independent monitor; a small core model feeds squeeze data.
module tb_mayo_shake_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        core_start, core_mode;
  logic [31:0] core_din;
  logic        core_din_last, core_din_valid;
  logic        core_din_ready = 1'b1;
  logic [31:0] core_dout;
  logic        core_dout_valid, core_dout_ready;

  always #5 ACLK = ~ACLK;

  mayo_shake_ctrl #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB), .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP (S_AXI_BRESP), .S_AXI_BVALID (S_AXI_BVALID), .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP), .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .core_start (core_start), .core_mode (core_mode),
    .core_din (core_din), .core_din_last (core_din_last), .core_din_valid (core_din_valid),
    .core_din_ready (core_din_ready),
    .core_dout (core_dout), .core_dout_valid (core_dout_valid), .core_dout_ready (core_dout_ready)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  typedef struct { logic [1:0] resp; string nm; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; string nm; } rexp_t;
  bexp_t exp_b[$];
  rexp_t exp_r[$];

  // Core model: squeeze words from a table, absorbed words logged with their LAST tag.
  logic [31:0] sq_vals [4];
  int          sq_lim = 0;
  int          sq_idx = 0;
  logic [32:0] din_log [8];
  int          din_cnt = 0;
  int          start_cnt = 0;

  assign core_dout_valid = sq_idx < sq_lim;
  assign core_dout       = sq_vals[sq_idx[1:0]];

  always @(posedge ACLK) begin
    if (core_dout_valid && core_dout_ready) sq_idx <= sq_idx + 1;
    if (!ARESET && core_din_valid && core_din_ready) begin
      din_log[din_cnt[2:0]] <= {core_din_last, core_din};
      din_cnt <= din_cnt + 1;
    end
    if (core_start) start_cnt <= start_cnt + 1;
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin : mon_b
        bexp_t e;
        if (exp_b.size() == 0) check("b_unexpected", {31'h0, S_AXI_BVALID}, 32'h0);
        else begin
          e = exp_b.pop_front();
          check({e.nm, "_bresp"}, {30'h0, S_AXI_BRESP}, {30'h0, e.resp});
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin : mon_r
        rexp_t e;
        if (exp_r.size() == 0) check("r_unexpected", {31'h0, S_AXI_RVALID}, 32'h0);
        else begin
          e = exp_r.pop_front();
          check({e.nm, "_rdata"}, S_AXI_RDATA, e.data);
          check({e.nm, "_rresp"}, {30'h0, S_AXI_RRESP}, {30'h0, e.resp});
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input string nm, output logic [1:0] drdy);
    int n;
    exp_b.push_back('{resp, nm});
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) check({nm, "_aw_timeout"}, 32'(n), 32'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    drdy[0] = core_dout_ready;
    @(negedge ACLK);
    drdy[1] = core_dout_ready;
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input string nm);
    int n;
    exp_r.push_back('{data, resp, nm});
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) check({nm, "_ar_timeout"}, 32'(n), 32'd0);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    logic [1:0] dr;
    int n, hits;

    sq_vals[0] = 32'hA5A5_0001; sq_vals[1] = 32'hA5A5_0002;
    sq_vals[2] = 32'h0;         sq_vals[3] = 32'h0;
    repeat (3) @(negedge ACLK);
    check("rst_handshakes", {20'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
          S_AXI_RVALID, core_start, core_din_valid, core_dout_ready, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    ARESET = 1'b0;

    axi_read(4'h4, 32'h0, 2'b00, "rst_status");

    axi_write(4'h8, 32'hDEAD_BEEF, 2'b10, "din_idle", dr);
    check("din_idle_valid", {31'h0, core_din_valid}, 32'h0);
    check("din_idle_count", 32'(din_cnt), 32'd0);
    axi_read(4'hC, 32'h0, 2'b10, "dout_empty");

    // Full run: SQ_LEN = 2, two absorbed words, second tagged LAST.
    sq_lim = 2;
    axi_write(4'h0, 32'h0002_0001, 2'b00, "ctrl_start", dr);
    check("start_pulses", 32'(start_cnt), 32'd1);
    check("core_mode", {31'h0, core_mode}, 32'h0);
    axi_read(4'h4, 32'h0000_0011, 2'b00, "stat_absorb");
    axi_write(4'h8, 32'h0000_0001, 2'b00, "din_w0", dr);
    axi_write(4'h0, 32'h0002_0004, 2'b00, "ctrl_last", dr);
    axi_write(4'h8, 32'h0000_0002, 2'b00, "din_w1", dr);
    axi_read(4'h4, 32'h0000_0025, 2'b00, "stat_squeeze");
    axi_read(4'hC, 32'hA5A5_0001, 2'b00, "dout0");
    axi_read(4'hC, 32'hA5A5_0002, 2'b00, "dout1");
    axi_read(4'h4, 32'h0000_0008, 2'b00, "stat_done");
    check("din_count", 32'(din_cnt), 32'd2);
    check("din_w0_data", din_log[0][31:0], 32'h1);
    check("din_w0_last", {31'h0, din_log[0][32]}, 32'h0);
    check("din_w1_data", din_log[1][31:0], 32'h2);
    check("din_w1_last", {31'h0, din_log[1][32]}, 32'h1);
    axi_write(4'h4, 32'h0, 2'b00, "stat_wr0", dr);
    axi_read(4'h4, 32'h0000_0008, 2'b00, "stat_done_hold");
    axi_write(4'h4, 32'h8, 2'b00, "stat_w1c", dr);
    axi_read(4'h4, 32'h0, 2'b00, "stat_cleared");

    // START while busy: one FLUSH cycle draining the core, then IDLE.
    axi_write(4'h0, 32'h0000_0001, 2'b00, "ctrl_start2", dr);
    axi_read(4'h4, 32'h0000_0011, 2'b00, "stat_absorb2");
    axi_write(4'h0, 32'h0000_0001, 2'b00, "ctrl_flush", dr);
    check("flush_drain", {30'h0, dr}, 32'h1);
    check("flush_no_start", 32'(start_cnt), 32'd2);
    axi_read(4'h4, 32'h0, 2'b00, "stat_flushed");

    // Core stalls absorb: second DIN write must wait for the buffer to drain.
    axi_write(4'h0, 32'h0000_0001, 2'b00, "ctrl_start3", dr);
    core_din_ready = 1'b0;
    axi_write(4'h8, 32'h0000_0011, 2'b00, "din_hold", dr);
    check("din_hold_valid", {31'h0, core_din_valid}, 32'h1);
    check("din_hold_data", core_din, 32'h11);
    exp_b.push_back('{2'b00, "din_stall"});
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h22; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY || S_AXI_WREADY) hits++;
    end
    check("stall_wready", 32'(hits), 32'd0);
    core_din_ready = 1'b1;
    n = 0;
    while (!S_AXI_WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) check("stall_release_timeout", 32'(n), 32'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    check("stall_din_count", 32'(din_cnt), 32'd4);
    check("stall_w0", din_log[2][31:0], 32'h11);
    check("stall_w1", din_log[3][31:0], 32'h22);

    // Reset lands between ready and handshake: the write is dropped, no response.
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) check("rst_mid_timeout", 32'(n), 32'd0);
    ARESET = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) hits++;
    end
    check("rst_mid_bvalid", 32'(hits), 32'd0);
    axi_read(4'h4, 32'h0, 2'b00, "stat_after_rst");

    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin @(negedge ACLK); n++; end
    check("pending_b", 32'(exp_b.size()), 32'd0);
    check("pending_r", 32'(exp_r.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mayo_shake_ctrl.md
MAYO_SHAKE_CTRL -- requirements
Module: mayo_shake_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width for the 4-register map.
REQ-003 SHALL have ports, clock and reset first:
- ACLK  in  1  single clock, all logic on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  4/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  4/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- core_start  out  1  one-cycle pulse that starts a SHAKE run.
- core_mode  out  1  0 = SHAKE128, 1 = SHAKE256; held stable while busy.
- core_din/core_din_last/core_din_valid/core_din_ready  out/out/out/in  32/1/1/1  absorb stream.
- core_dout/core_dout_valid/core_dout_ready  in/in/out  32/1/1  squeeze stream.

Function
REQ-004 SHALL decode 4 word registers: 0x0 CTRL, 0x4 STATUS, 0x8 DIN, 0xC DOUT; AWADDR/ARADDR[1:0] ignored.
REQ-005 CTRL write SHALL set: bit0 START (self-clearing, reads 0), bit1 MODE, bit2 LAST (tags the next DIN word), bits[23:16] SQ_LEN, the number of squeeze words; 0 means 256.
REQ-006 STATUS read SHALL return: bit0 BUSY, bit1 DIN_FULL, bit2 DOUT_VALID, bit3 DONE, bits[5:4] state encoding; a write with bit3 = 1 SHALL clear DONE (W1C).
REQ-007 FSM states SHALL be IDLE(0), ABSORB(1), SQUEEZE(2), FLUSH(3).
- IDLE->ABSORB: CTRL write with START=1; core_start pulses one cycle; MODE and SQ_LEN are latched.
- ABSORB->SQUEEZE: the core accepts a word tagged LAST.
- SQUEEZE->IDLE: SQ_LEN words have been popped via DOUT; DONE is set the same cycle.
- FLUSH: entered on CTRL write with START=1 while not IDLE; drains (acks) core_dout for 1 cycle, then goes to IDLE with DONE cleared.
REQ-008 Write path SHALL assert AWREADY and WREADY together for one cycle only when AWVALID, WVALID and !BVALID are all true, and, for DIN, the holding buffer is empty; BVALID follows 1 cycle later and holds until BREADY.
REQ-009 DIN SHALL use a 1-entry holding buffer driving core_din_valid; the buffer empties on core_din_valid & core_din_ready; core_din_last is the captured LAST bit, and LAST clears after capture.
REQ-010 A DIN write outside ABSORB SHALL return BRESP=SLVERR(2'b10) and discard the data; all other writes SHALL return OKAY.
REQ-011 Squeeze path SHALL capture core_dout into a 1-entry buffer; core_dout_ready = SQUEEZE & buffer empty.
REQ-012 Read path SHALL assert ARREADY when ARVALID & !RVALID; RVALID rises 1 cycle later and holds until RREADY.
REQ-013 A DOUT read with the buffer empty SHALL return RDATA=0 and RRESP=SLVERR; a valid DOUT read returns the word with OKAY, empties the buffer and increments the squeeze counter.
REQ-014 The squeeze counter SHALL be 9 bits, compare against SQ_LEN (with 0 mapped to 256), and SHALL NOT wrap.
REQ-015 When a read and a write complete in the same cycle, both SHALL be served; a same-cycle STATUS W1C and DONE set SHALL leave DONE = 1.

Reset
REQ-016 ARESET SHALL force within 1 cycle: state IDLE, all READY/VALID outputs 0, core_start 0, core_din_valid 0, core_dout_ready 0, BRESP/RRESP 0, RDATA 0, CTRL and STATUS fields 0, buffers empty, counter 0.
REQ-017 ARESET asserted mid-transaction SHALL abandon the transaction; no B/R response is produced for it.

Structure
REQ-018 A shared package mayo_shake_pkg SHALL hold the state enum, register offset constants, CTRL/STATUS bit indices and the RESP_OKAY/RESP_SLVERR constants.
REQ-019 The AXI4-Lite handshake/response logic SHALL be one sub-module mayo_axil_regif; the FSM and buffers live in mayo_shake_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset -> STATUS reads 0x0000_0000, OKAY.
- CTRL=0x0002_0001, DIN 0x1 and 0x2 (with LAST set before the 2nd word), core model returns 0xA5A5_0001 and 0xA5A5_0002 -> two DOUT reads return those values, then STATUS bit3 = 1 and state = 0.
- DIN write while IDLE -> BRESP=2'b10, core_din_valid stays 0.
- DOUT read with empty buffer -> RDATA=0, RRESP=2'b10.
- START in ABSORB -> FLUSH then IDLE within 2 cycles, DONE = 0.
- core_din_ready held low 10 cycles -> second DIN write stalls (WREADY = 0) until the first word is accepted; ARESET mid-write -> no BVALID.
